// File: rtl/aes_iter_engine.sv
// rtl/aes_iter_engine.sv - iterative AES-128/192/256 round sequencer driving an external round unit
// Optional CBC chaining enabled by defining AES_CBC_EN.
module aes_iter_engine #(
   parameter int NK = 4,
   parameter int NR = NK + 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [128*(NR+1)-1:0] all_keys,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [127:0]          in_data,
   input  logic                  in_decrypt,
   input  logic                  abort,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [127:0]          out_data,
   output logic                  busy,
   output logic [3:0]            round_cnt,
   output logic [127:0]          rnd_state_o,
   output logic [127:0]          rnd_key_o,
   output logic                  rnd_inv_o,
   output logic                  rnd_last_o,
`ifdef AES_CBC_EN
   input  logic                  iv_load,
   input  logic [127:0]          iv,
`endif
   input  logic [127:0]          rnd_state_i
);

   generate
      if (!(NK == 4 || NK == 6 || NK == 8) || NR != NK + 6) begin : gen_bad_param
         $error("aes_iter_engine: NK must be 4, 6 or 8 and NR must equal NK+6");
      end
   endgenerate

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [3:0] NR4     = 4'(NR);

   logic [1:0]   state;
   logic [127:0] state_reg;
   logic         mode;
   logic         accept;
   logic         out_fire;
   logic         kill;
   logic [3:0]   key_idx;
   logic [127:0] key_first;
   logic [127:0] key_last;
   logic [127:0] init_state;
   logic [127:0] result;

   assign key_first = all_keys[NR*128 +: 128];
   assign key_last  = all_keys[0 +: 128];
   assign out_fire  = out_valid & out_ready;
   assign kill      = abort & (state != S_IDLE);

   // in_ready falls during reset and whenever abort is raised, whatever the state
   always_comb begin
      in_ready = 1'b0;
      if (rst_n && !abort) begin
         case (state)
            S_IDLE:  in_ready = 1'b1;
            S_DONE:  in_ready = out_ready;
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign accept = in_valid & in_ready;

`ifdef AES_CBC_EN
   logic [127:0] chain;
   logic [127:0] chain_eff;
   logic [127:0] dec_xor;

   assign chain_eff  = (iv_load && state == S_IDLE) ? iv : chain;
   assign init_state = in_data ^ (in_decrypt ? key_last : (key_first ^ chain_eff));
   assign result     = mode ? (rnd_state_i ^ dec_xor) : rnd_state_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain   <= '0;
         dec_xor <= '0;
      end else if (accept) begin
         chain <= in_decrypt ? in_data : chain_eff;
         if (in_decrypt) dec_xor <= chain_eff;
      end else if (state == S_ROUND && round_cnt == NR4 && !mode && !kill) begin
         chain <= rnd_state_i;
      end else if (state == S_IDLE && iv_load) begin
         chain <= iv;
      end
   end
`else
   assign init_state = in_data ^ (in_decrypt ? key_last : key_first);
   assign result     = rnd_state_i;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         state_reg <= '0;
         mode      <= 1'b0;
         round_cnt <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (kill) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         round_cnt <= '0;
      end else if (accept) begin
         state     <= S_ROUND;
         state_reg <= init_state;
         mode      <= in_decrypt;
         round_cnt <= 4'd1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_ROUND: begin
               state_reg <= rnd_state_i;
               if (round_cnt == NR4) begin
                  out_data  <= result;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  round_cnt <= round_cnt + 4'd1;
               end
            end
            S_DONE: begin
               if (out_fire) begin
                  out_valid <= 1'b0;
                  round_cnt <= '0;
                  state     <= S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Decrypt walks the schedule backwards from key NR
   assign key_idx = mode ? (NR4 - round_cnt) : round_cnt;

   always_comb begin
      rnd_key_o = '0;
      for (int i = 0; i <= NR; i++) begin
         if (key_idx == 4'(i)) rnd_key_o = all_keys[(NR-i)*128 +: 128];
      end
   end

   assign busy        = (state == S_ROUND);
   assign rnd_state_o = state_reg;
   assign rnd_inv_o   = mode;
   assign rnd_last_o  = (round_cnt == NR4);

endmodule

// File: tb/tb_aes_iter_engine.sv
// tb/tb_aes_iter_engine.sv - scoreboard bench for aes_iter_engine with NK=4/6/8 instances
module tb_aes_iter_engine;

   typedef struct {
      int           inst;
      logic [127:0] data;
      longint       t;
   } exp_t;

   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_CBC_EN
   localparam bit CBC_ON = 1'b1;
`else
   localparam bit CBC_ON = 1'b0;
`endif

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   longint cyc = 0;
   int     checks = 0;
   int     errors = 0;
   exp_t   exp_q[$];

   logic [1919:0] keys [3];
   logic          in_valid [3];
   logic          in_ready [3];
   logic [127:0]  in_data [3];
   logic          in_decrypt [3];
   logic          abort [3];
   logic          out_valid [3];
   logic          out_ready [3];
   logic [127:0]  out_data [3];
   logic          busy [3];
   logic [3:0]    round_cnt [3];
   logic [127:0]  rnd_state_o [3];
   logic [127:0]  rnd_key [3];
   logic          rnd_inv [3];
   logic          rnd_last [3];
   logic [127:0]  rnd_state_i [3];
`ifdef AES_CBC_EN
   logic          iv_load [3];
   logic [127:0]  iv [3];
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8)
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gmul(r, r);
         if (i != 0) r = gmul(r, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] d = {x, x};
      return d[15-n -: 8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] i = ginv(a);
      return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return ginv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic inv, input logic last);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [7:0]   m [4];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!inv) b[r+4*c] = sbox(a[r+4*((c+r)%4)]);
            else      b[r+4*((c+r)%4)] = inv_sbox(a[r+4*c]);
      if (inv) for (int i = 0; i < 16; i++) b[i] ^= k[127-8*i -: 8];
      if (!last) begin
         if (inv) m = '{8'd14, 8'd11, 8'd13, 8'd9};
         else     m = '{8'd2, 8'd3, 8'd1, 8'd1};
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
               a[r+4*c] = 8'h00;
               for (int j = 0; j < 4; j++) a[r+4*c] ^= gmul(m[(j-r+4)%4], b[j+4*c]);
            end
         b = a;
      end
      if (!inv) for (int i = 0; i < 16; i++) b[i] ^= k[127-8*i -: 8];
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
      return o;
   endfunction

   function automatic logic [1919:0] expand(input int nk);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [255:0]  key = '0;
      logic [7:0]    rc = 8'h01;
      logic [1919:0] ak = '0;
      int            nr = nk + 6;
      for (int i = 0; i < 4*nk; i++) key[255-8*i -: 8] = 8'(i);
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i <= nr; i++) ak[(nr-i)*128 +: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
      return ak;
   endfunction

   function automatic logic [127:0] aes_ref(input int nr, input logic [1919:0] ak,
                                            input logic [127:0] blk, input logic dec);
      logic [127:0] s = blk ^ ak[(nr - (dec ? nr : 0))*128 +: 128];
      for (int r = 1; r <= nr; r++) s = aes_round(s, ak[(nr - (dec ? nr - r : r))*128 +: 128], dec, r == nr);
      return s;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int NKG = 4 + 2*g;
      localparam int NRG = NKG + 6;
      logic   prev_v = 1'b0;
      longint rise_cyc = 0;
      exp_t   e;

      aes_iter_engine #(.NK(NKG)) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .all_keys    (keys[g][128*(NRG+1)-1:0]),
         .in_valid    (in_valid[g]),
         .in_ready    (in_ready[g]),
         .in_data     (in_data[g]),
         .in_decrypt  (in_decrypt[g]),
         .abort       (abort[g]),
         .out_valid   (out_valid[g]),
         .out_ready   (out_ready[g]),
         .out_data    (out_data[g]),
         .busy        (busy[g]),
         .round_cnt   (round_cnt[g]),
         .rnd_state_o (rnd_state_o[g]),
         .rnd_key_o   (rnd_key[g]),
         .rnd_inv_o   (rnd_inv[g]),
         .rnd_last_o  (rnd_last[g]),
`ifdef AES_CBC_EN
         .iv_load     (iv_load[g]),
         .iv          (iv[g]),
`endif
         .rnd_state_i (rnd_state_i[g])
      );

      assign rnd_state_i[g] = aes_round(rnd_state_o[g], rnd_key[g], rnd_inv[g], rnd_last[g]);

      always begin
         @(negedge clk);
         #2;
         if (out_valid[g] && !prev_v) rise_cyc = cyc;
         prev_v = out_valid[g];
         if (out_valid[g] && out_ready[g] && !abort[g]) begin
            if (exp_q.size() == 0) begin
               check($sformatf("i%0d_spurious_out_valid", g), out_valid[g], 128'd0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("i%0d_sb_inst", g), g, e.inst);
               check($sformatf("i%0d_out_data", g), out_data[g], e.data);
               check($sformatf("i%0d_latency", g), rise_cyc - e.t, NRG + 1);
            end
         end
      end
   end

   task automatic send(input int g, input logic [127:0] d, input logic dec, input logic [127:0] e);
      int n = 0;
      in_valid[g] = 1'b1;
      in_data[g] = d;
      in_decrypt[g] = dec;
      #1;
      while (!in_ready[g] && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready[g]) check("accept_timeout", in_ready[g], 128'd1);
      else exp_q.push_back('{g, e, cyc});
      @(negedge clk);
      in_valid[g] = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", exp_q.size(), 128'd0);
      @(negedge clk);
   endtask

   task automatic wait_valid(input int g);
      int n = 0;
      while (!out_valid[g] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wait_out_valid", out_valid[g], 128'd1);
   endtask

   task automatic wait_rc(input int g, input logic [3:0] v);
      int n = 0;
      while (round_cnt[g] != v && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wait_round_cnt", round_cnt[g], v);
   endtask

   task automatic zero_iv(input int g);
`ifdef AES_CBC_EN
      iv[g] = '0;
      iv_load[g] = 1'b1;
      @(negedge clk);
      iv_load[g] = 1'b0;
`else
      in_valid[g] = 1'b0;
`endif
   endtask

   initial begin
      logic [127:0] blk;
      logic [127:0] ct;
      logic [127:0] b2b_exp;
      logic [127:0] c2;
      for (int g = 0; g < 3; g++) begin
         keys[g] = expand(4 + 2*g);
         in_valid[g] = 1'b0;
         in_data[g] = '0;
         in_decrypt[g] = 1'b0;
         abort[g] = 1'b0;
         out_ready[g] = 1'b1;
`ifdef AES_CBC_EN
         iv_load[g] = 1'b0;
         iv[g] = '0;
`endif
      end
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready[0], 128'd0);
      check("rst_out_valid", out_valid[0], 128'd0);
      check("rst_out_data", out_data[0], 128'd0);
      check("rst_busy", busy[0], 128'd0);
      check("rst_round_cnt", round_cnt[0], 128'd0);
      check("rst_state_reg", rnd_state_o[0], 128'd0);
      rst_n = 1'b1;
      #1;
      check("idle_in_ready", in_ready[0], 128'd1);
      @(negedge clk);

      send(0, PT, 1'b0, CT128);
      wait_drain();
      send(1, PT, 1'b0, CT192);
      wait_drain();
      send(2, PT, 1'b0, CT256);
      wait_drain();

      // decrypt held under backpressure, then released together with the next request
      zero_iv(0);
      out_ready[0] = 1'b0;
      send(0, CT128, 1'b1, PT);
      in_valid[0] = 1'b1;
      #1;
      check("round_in_ready", in_ready[0], 128'd0);
      check("round_busy", busy[0], 128'd1);
      in_valid[0] = 1'b0;
      wait_valid(0);
      repeat (5) begin
         @(negedge clk);
         check("hold_out_valid", out_valid[0], 128'd1);
         check("hold_out_data", out_data[0], PT);
         check("hold_in_ready", in_ready[0], 128'd0);
      end
      out_ready[0] = 1'b1;
      b2b_exp = CBC_ON ? aes_ref(10, keys[0], PT ^ CT128, 1'b0) : CT128;
      send(0, PT, 1'b0, b2b_exp);
      check("b2b_busy", busy[0], 128'd1);
      check("b2b_round_cnt", round_cnt[0], 128'd1);
      wait_drain();

      for (int g = 0; g < 3; g++) begin
         blk = {$urandom, $urandom, $urandom, $urandom};
         ct = aes_ref(10 + 2*g, keys[g], blk, 1'b0);
         zero_iv(g);
         send(g, blk, 1'b0, ct);
         wait_drain();
         zero_iv(g);
         send(g, ct, 1'b1, blk);
         wait_drain();
      end

      abort[0] = 1'b1;
      #1;
      check("idle_abort_in_ready", in_ready[0], 128'd0);
      @(negedge clk);
      abort[0] = 1'b0;
      #1;
      check("idle_after_abort_ready", in_ready[0], 128'd1);
      @(negedge clk);

      send(0, PT, 1'b0, CT128);
      void'(exp_q.pop_back());
      wait_rc(0, 4'd5);
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      #1;
      check("abort_busy", busy[0], 128'd0);
      check("abort_round_cnt", round_cnt[0], 128'd0);
      check("abort_out_valid", out_valid[0], 128'd0);
      check("abort_in_ready", in_ready[0], 128'd1);
      repeat (16) @(negedge clk);
      check("abort_no_result", out_valid[0], 128'd0);

      // abort in DONE wins over a simultaneous consume-and-accept
      out_ready[0] = 1'b0;
      send(0, PT, 1'b0, CT128);
      void'(exp_q.pop_back());
      wait_valid(0);
      out_ready[0] = 1'b1;
      abort[0] = 1'b1;
      in_valid[0] = 1'b1;
      in_data[0] = PT;
      in_decrypt[0] = 1'b0;
      @(negedge clk);
      abort[0] = 1'b0;
      in_valid[0] = 1'b0;
      #1;
      check("done_abort_out_valid", out_valid[0], 128'd0);
      check("done_abort_busy", busy[0], 128'd0);
      @(negedge clk);

      send(1, PT, 1'b0, CT192);
      void'(exp_q.pop_back());
      wait_rc(1, 4'd3);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy[1], 128'd0);
      check("arst_round_cnt", round_cnt[1], 128'd0);
      check("arst_out_valid", out_valid[1], 128'd0);
      check("arst_out_data", out_data[1], 128'd0);
      check("arst_in_ready", in_ready[1], 128'd0);
      check("arst_state_reg", rnd_state_o[1], 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef AES_CBC_EN
      c2 = aes_ref(10, keys[0], PT ^ CT128, 1'b0);
      zero_iv(0);
      send(0, PT, 1'b0, CT128);
      send(0, PT, 1'b0, c2);
      wait_drain();
      zero_iv(0);
      send(0, CT128, 1'b1, PT);
      send(0, c2, 1'b1, PT);
      wait_drain();
`else
      c2 = '0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
